bin2bcd_conv: RTL and testbench

Sequential binary-to-BCD converter that produces the packed BCD words consumed by the seven-segment display decoder (`seg_disp`). It takes the binary fare total and the binary distance from the fare/mileage counters and converts both in parallel using shift-and-add-3 (double dabble). It presents `fare_total_bcd` and `distance_bcd` as registered, stable outputs, with a one-cycle `done` strobe. Out-of-range inputs saturate to all-nines, with a sticky-per-result overflow flag.

---
 rtl/bin2bcd_conv_if.sv | 23 ++
 rtl/bin2bcd_conv.sv | 136 +++++++++++++
 tb/tb_bin2bcd_conv.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/bin2bcd_conv_if.sv
// Request/result bundle between the fare/mileage counters, the BCD converter
// and the seven-segment decoder.
interface bin2bcd_conv_if;
    logic        start;
    logic [13:0] fare_total;
    logic [6:0]  distance;
    logic [15:0] fare_total_bcd;
    logic [7:0]  distance_bcd;
    logic        fare_ovf;
    logic        dist_ovf;
    logic        busy;
    logic        done;

    modport master (
        output start, fare_total, distance,
        input  fare_total_bcd, distance_bcd, fare_ovf, dist_ovf, busy, done
    );

    modport slave (
        input  start, fare_total, distance,
        output fare_total_bcd, distance_bcd, fare_ovf, dist_ovf, busy, done
    );
endinterface

// File: rtl/bin2bcd_conv.sv
// Sequential double-dabble converter: fare (4 digits) and distance (2 digits)
// converted in parallel over 14 shifts, with saturation to all-nines.
module bin2bcd_conv #(
    parameter int FARE_MAX = 9999,
    parameter int DIST_MAX = 99
) (
    input  logic clk,
    input  logic rst_n,
    bin2bcd_conv_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [13:0] FARE_LIM = 14'(FARE_MAX);
    localparam logic [6:0]  DIST_LIM = 7'(DIST_MAX);

    state_t      state_reg, state_next;
    logic [13:0] fare_sr_reg, fare_sr_next;
    logic [13:0] dist_sr_reg, dist_sr_next;
    logic [15:0] fare_acc_reg, fare_acc_next, fare_adj, fare_shift;
    logic [7:0]  dist_acc_reg, dist_acc_next, dist_adj, dist_shift;
    logic [3:0]  cnt_reg, cnt_next;
    logic        fare_pend_reg, fare_pend_next;
    logic        dist_pend_reg, dist_pend_next;
    logic [15:0] fare_bcd_reg, fare_bcd_next;
    logic [7:0]  dist_bcd_reg, dist_bcd_next;
    logic        fare_ovf_reg, fare_ovf_next;
    logic        dist_ovf_reg, dist_ovf_next;
    logic        fare_over, dist_over;

    // Add-3 correction per digit, applied to the value about to be shifted.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_fare_adj
            assign fare_adj[gi*4 +: 4] = (fare_acc_reg[gi*4 +: 4] >= 4'd5) ?
                                         fare_acc_reg[gi*4 +: 4] + 4'd3 :
                                         fare_acc_reg[gi*4 +: 4];
        end
        for (gi = 0; gi < 2; gi++) begin : g_dist_adj
            assign dist_adj[gi*4 +: 4] = (dist_acc_reg[gi*4 +: 4] >= 4'd5) ?
                                         dist_acc_reg[gi*4 +: 4] + 4'd3 :
                                         dist_acc_reg[gi*4 +: 4];
        end
    endgenerate

    assign fare_shift = {fare_adj[14:0], fare_sr_reg[13]};
    assign dist_shift = {dist_adj[6:0],  dist_sr_reg[13]};
    assign fare_over  = (bus.fare_total > FARE_LIM);
    assign dist_over  = (bus.distance > DIST_LIM);

    always_comb begin
        state_next     = state_reg;
        fare_sr_next   = fare_sr_reg;
        dist_sr_next   = dist_sr_reg;
        fare_acc_next  = fare_acc_reg;
        dist_acc_next  = dist_acc_reg;
        cnt_next       = cnt_reg;
        fare_pend_next = fare_pend_reg;
        dist_pend_next = dist_pend_reg;
        fare_bcd_next  = fare_bcd_reg;
        dist_bcd_next  = dist_bcd_reg;
        fare_ovf_next  = fare_ovf_reg;
        dist_ovf_next  = dist_ovf_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    fare_sr_next   = fare_over ? FARE_LIM : bus.fare_total;
                    dist_sr_next   = {7'd0, (dist_over ? DIST_LIM : bus.distance)};
                    fare_pend_next = fare_over;
                    dist_pend_next = dist_over;
                    fare_acc_next  = '0;
                    dist_acc_next  = '0;
                    cnt_next       = '0;
                    state_next     = SHIFT;
                end
            end
            SHIFT: begin
                fare_acc_next = fare_shift;
                dist_acc_next = dist_shift;
                fare_sr_next  = {fare_sr_reg[12:0], 1'b0};
                dist_sr_next  = {dist_sr_reg[12:0], 1'b0};
                cnt_next      = cnt_reg + 4'd1;
                // Last shift: publish the final accumulators on the same edge.
                if (cnt_reg == 4'd13) begin
                    fare_bcd_next = fare_shift;
                    dist_bcd_next = dist_shift;
                    fare_ovf_next = fare_pend_reg;
                    dist_ovf_next = dist_pend_reg;
                    state_next    = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            fare_sr_reg   <= '0;
            dist_sr_reg   <= '0;
            fare_acc_reg  <= '0;
            dist_acc_reg  <= '0;
            cnt_reg       <= '0;
            fare_pend_reg <= 1'b0;
            dist_pend_reg <= 1'b0;
            fare_bcd_reg  <= '0;
            dist_bcd_reg  <= '0;
            fare_ovf_reg  <= 1'b0;
            dist_ovf_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            fare_sr_reg   <= fare_sr_next;
            dist_sr_reg   <= dist_sr_next;
            fare_acc_reg  <= fare_acc_next;
            dist_acc_reg  <= dist_acc_next;
            cnt_reg       <= cnt_next;
            fare_pend_reg <= fare_pend_next;
            dist_pend_reg <= dist_pend_next;
            fare_bcd_reg  <= fare_bcd_next;
            dist_bcd_reg  <= dist_bcd_next;
            fare_ovf_reg  <= fare_ovf_next;
            dist_ovf_reg  <= dist_ovf_next;
        end
    end

    assign bus.fare_total_bcd = fare_bcd_reg;
    assign bus.distance_bcd   = dist_bcd_reg;
    assign bus.fare_ovf       = fare_ovf_reg;
    assign bus.dist_ovf       = dist_ovf_reg;
    assign bus.busy           = (state_reg != IDLE);
    assign bus.done           = (state_reg == DONE);
endmodule

// File: tb/tb_bin2bcd_conv.sv
// Scoreboard bench for bin2bcd_conv: directed conversions push hand-computed
// results; a negedge monitor pops and compares on every done strobe.
module tb_bin2bcd_conv;
    logic clk = 1'b0;
    logic rst_n;
    bin2bcd_conv_if bus();

    bin2bcd_conv #(.FARE_MAX(9999), .DIST_MAX(99)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] f;
        logic [7:0]  d;
        logic        fo;
        logic        dov;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   done_count = 0;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: one line per completed transaction.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.done === 1'b1) begin
            exp_t e;
            done_count++;
            chk("done_single_cycle", {31'd0, prev_done}, 32'd0);
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=%h/%h required=none",
                         bus.fare_total_bcd, bus.distance_bcd);
            end else begin
                e = q.pop_front();
                $display("txn fare_bcd=%h dist_bcd=%h fovf=%b dovf=%b latency=%0d",
                         bus.fare_total_bcd, bus.distance_bcd, bus.fare_ovf,
                         bus.dist_ovf, cyc - e.acc);
                chk("fare_total_bcd", {16'd0, bus.fare_total_bcd}, {16'd0, e.f});
                chk("distance_bcd",   {24'd0, bus.distance_bcd},   {24'd0, e.d});
                chk("fare_ovf",       {31'd0, bus.fare_ovf},       {31'd0, e.fo});
                chk("dist_ovf",       {31'd0, bus.dist_ovf},       {31'd0, e.dov});
                chk("latency",        32'(cyc - e.acc),            32'd14);
            end
        end
        prev_done = (rst_n === 1'b1) ? bus.done : 1'b0;
    end

    task automatic issue(input int f, input int d, input logic [15:0] ef,
                         input logic [7:0] ed, input logic fo, input logic dov,
                         input bit keep, input bit push, output int acc);
        int g;
        exp_t e;
        g = 0;
        @(negedge clk);
        while (bus.busy && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (bus.busy) begin
            checks++;
            failures++;
            $display("FAIL issue_wait_idle actual=busy required=idle");
        end
        bus.start      = 1'b1;
        bus.fare_total = 14'(f);
        bus.distance   = 7'(d);
        @(posedge clk);
        #1;
        acc = cyc;
        if (push) begin
            e.f = ef; e.d = ed; e.fo = fo; e.dov = dov; e.acc = acc;
            q.push_back(e);
        end
        if (!keep) bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((q.size() != 0 || bus.busy) && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) begin
            checks++;
            failures++;
            $display("FAIL wait_idle_timeout actual=pending=%0d required=pending=0", q.size());
        end
        @(negedge clk);
    endtask

    initial begin
        int acc;
        int dc0;
        exp_t e;
        bus.start      = 1'b0;
        bus.fare_total = '0;
        bus.distance   = '0;
        rst_n          = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_fare_bcd", {16'd0, bus.fare_total_bcd}, 32'd0);
        chk("rst_dist_bcd", {24'd0, bus.distance_bcd},   32'd0);
        chk("rst_fare_ovf", {31'd0, bus.fare_ovf},       32'd0);
        chk("rst_dist_ovf", {31'd0, bus.dist_ovf},       32'd0);
        chk("rst_busy",     {31'd0, bus.busy},           32'd0);
        chk("rst_done",     {31'd0, bus.done},           32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(1234, 56,    16'h1234, 8'h56, 1'b0, 1'b0, 0, 1, acc); wait_idle();
        issue(0,    0,     16'h0000, 8'h00, 1'b0, 1'b0, 0, 1, acc); wait_idle();
        issue(9999, 99,    16'h9999, 8'h99, 1'b0, 1'b0, 0, 1, acc); wait_idle();
        issue(1000, 10,    16'h1000, 8'h10, 1'b0, 1'b0, 0, 1, acc); wait_idle();
        issue(10000, 100,  16'h9999, 8'h99, 1'b1, 1'b1, 0, 1, acc); wait_idle();
        issue(16383, 127,  16'h9999, 8'h99, 1'b1, 1'b1, 0, 1, acc); wait_idle();
        issue(9998, 127,   16'h9998, 8'h99, 1'b0, 1'b1, 0, 1, acc); wait_idle();

        // Start pulse and input changes while busy must not disturb the result.
        dc0 = done_count;
        issue(4321, 87, 16'h4321, 8'h87, 1'b0, 1'b0, 0, 1, acc);
        repeat (4) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.fare_total = 14'd1111; bus.distance = 7'd22;
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.fare_total = 14'd2222; bus.distance = 7'd111;
        repeat (3) @(posedge clk);
        #1;
        bus.fare_total = 14'd16383; bus.distance = 7'd127;
        wait_idle();
        repeat (20) @(negedge clk);
        chk("ignore_done_count", 32'(done_count - dc0), 32'd1);

        // Held start: back-to-back accepts 16 clocks apart.
        dc0 = done_count;
        issue(250, 7, 16'h0250, 8'h07, 1'b0, 1'b0, 1, 1, acc);
        bus.fare_total = 14'd251; bus.distance = 7'd8;
        e.f = 16'h0251; e.d = 8'h08; e.fo = 1'b0; e.dov = 1'b0; e.acc = acc + 16;
        q.push_back(e);
        repeat (16) @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_idle();
        chk("held_done_count", 32'(done_count - dc0), 32'd2);

        // Reset mid-conversion aborts with outputs cleared and no done.
        dc0 = done_count;
        issue(5678, 34, 16'h5678, 8'h34, 1'b0, 1'b0, 0, 0, acc);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_fare_bcd", {16'd0, bus.fare_total_bcd}, 32'd0);
        chk("abort_dist_bcd", {24'd0, bus.distance_bcd},   32'd0);
        chk("abort_busy",     {31'd0, bus.busy},           32'd0);
        chk("abort_done",     {31'd0, bus.done},           32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_no_done", 32'(done_count - dc0), 32'd0);
        issue(5678, 34, 16'h5678, 8'h34, 1'b0, 1'b0, 0, 1, acc); wait_idle();

        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
